// File: rtl/fmax_reduce_if.sv
// Stream bundle for fmax_reduce: element input stream plus one-beat result stream.
// master drives elements and result ready; slave is the reduction unit.
interface fmax_reduce_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
endinterface

// File: rtl/fmax_reduce.sv
// Streaming IEEE-754 single max-reduction; FMAX_NAN_EN selects maxNum NaN handling.
// Latency: result valid the cycle after the last element is accepted; 1 element/cycle.
// Backpressure: input stalls (in_ready=0) while a result waits; result held until out_ready.
module fmax_reduce #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    fmax_reduce_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ACCUM, DONE} state_t;

    state_t           state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             in_xfer;
    logic             out_xfer;
    logic [31:0]      acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Sign-magnitude ordering on raw bits; equal patterns are not greater.
    function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
        logic r;
        if (a[31] != b[31])
            r = ~a[31];
        else if (!a[31])
            r = (a[30:0] > b[30:0]);
        else
            r = (a[30:0] < b[30:0]);
        return r;
    endfunction

`ifdef FMAX_NAN_EN
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] v);
        return (&v[30:23]) && (|v[22:0]);
    endfunction
`endif

    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = out_valid_q && bus.out_ready;

    always_comb begin
        acc_nxt = acc;
`ifdef FMAX_NAN_EN
        if (state == EMPTY)
            acc_nxt = bus.in_data;
        else if (is_nan(bus.in_data))
            acc_nxt = acc;
        else if (is_nan(acc))
            acc_nxt = bus.in_data;
        else if (gt(bus.in_data, acc))
            acc_nxt = bus.in_data;
        // A NaN surviving to the last element means every element was NaN.
        if (bus.in_last && is_nan(acc_nxt))
            acc_nxt = QNAN;
`else
        if (state == EMPTY || gt(bus.in_data, acc))
            acc_nxt = bus.in_data;
`endif
    end

    always_comb begin
        cnt_nxt = cnt;
        if (state == EMPTY)
            cnt_nxt = CNT_W'(1);
        else if (!(&cnt))
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            acc         <= 32'h0000_0000;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY, ACCUM: begin
                    if (in_xfer) begin
                        acc <= acc_nxt;
                        cnt <= cnt_nxt;
                        if (bus.in_last) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_xfer) begin
                        state       <= EMPTY;
                        cnt         <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc;
    assign bus.out_count = cnt;
endmodule

// File: tb/tb_fmax_reduce.sv
// Bench for fmax_reduce: two instances (CNT_W=16 and CNT_W=2) fed identical streams,
// expected results queued at stimulus time and compared when each result beat appears.
module tb_fmax_reduce;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fmax_reduce_if #(.CNT_W(16)) ifa ();
    fmax_reduce_if #(.CNT_W(2))  ifb ();

    fmax_reduce #(.CNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    fmax_reduce #(.CNT_W(2))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct {
        logic [31:0] d;
        int          ca;
        int          cb;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pkt[8];

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        ifa.in_valid = v; ifa.in_data = d; ifa.in_last = l;
        ifb.in_valid = v; ifb.in_data = d; ifb.in_last = l;
    endtask

    task automatic set_ready(input logic r);
        ifa.out_ready = r;
        ifb.out_ready = r;
    endtask

    // Sends pkt[0..n-1]; lat reports out_valid right after the last accepting edge.
    task automatic send(input int n, output bit ok, output bit lat);
        ok  = 1'b1;
        lat = 1'b0;
        for (int i = 0; i < n; i++) begin
            int w;
            drive(1'b1, pkt[i], (i == n - 1));
            w = 0;
            while (!(ifa.in_ready && ifb.in_ready) && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            if (!(ifa.in_ready && ifb.in_ready)) ok = 1'b0;
            @(posedge clk); #1;
        end
        lat = ifa.out_valid && ifb.out_valid;
        drive(1'b0, 32'h0, 1'b0);
    endtask

    task automatic recv(output bit ok, output logic [31:0] da, output int ca,
                        output logic [31:0] db, output int cb);
        int w;
        w = 0;
        set_ready(1'b1);
        while (!(ifa.out_valid && ifb.out_valid) && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        ok = ifa.out_valid && ifb.out_valid;
        da = ifa.out_data;
        ca = int'(ifa.out_count);
        db = ifb.out_data;
        cb = int'(ifb.out_count);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b/%b want 0", ifa.out_valid, ifb.out_valid);
        end
        checks++;
        if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b/%b want 1", ifa.in_ready, ifb.in_ready);
        end
        checks++;
        if (ifa.out_data !== 32'h0 || ifa.out_count !== 16'd0 || ifb.out_count !== 2'd0) begin
            errors++; $display("FAIL reset_out got data %h count %0d/%0d want 0", ifa.out_data, ifa.out_count, ifb.out_count);
        end
        rst = 1'b0;
    endtask

    // Table of packets: lengths, elements, expected max and counts.
    task automatic run_table(input string name, input int npk, input int lens[4],
                             input logic [31:0] elems[4][8], input logic [31:0] want[4],
                             input int wa[4], input int wb[4]);
        bit ok, lat, rok;
        logic [31:0] da, db;
        int ca, cb;
        exp_t e;
        for (int p = 0; p < npk; p++) begin
            for (int i = 0; i < 8; i++) pkt[i] = elems[p][i];
            sb.push_back('{want[p], wa[p], wb[p]});
            send(lens[p], ok, lat);
            checks++;
            if (!ok || !lat) begin
                errors++; $display("FAIL %s_latency pkt %0d got accept %b valid %b want 1 1", name, p, ok, lat);
            end
            recv(rok, da, ca, db, cb);
            e = sb.pop_front();
            checks++;
            if (!rok) begin
                errors++; $display("FAIL %s_timeout pkt %0d no result beat", name, p);
            end
            checks++;
            if (da !== e.d || db !== e.d) begin
                errors++; $display("FAIL %s_data pkt %0d got %h/%h want %h", name, p, da, db, e.d);
            end
            checks++;
            if (ca !== e.ca || cb !== e.cb) begin
                errors++; $display("FAIL %s_count pkt %0d got %0d/%0d want %0d/%0d", name, p, ca, cb, e.ca, e.cb);
            end
        end
    endtask

    task automatic test_basic;
        int lens[4] = '{3, 0, 0, 0};
        logic [31:0] el[4][8] = '{default: '{default: 32'h0}};
        logic [31:0] want[4] = '{32'h40400000, 0, 0, 0};
        int wa[4] = '{3, 0, 0, 0};
        int wb[4] = '{3, 0, 0, 0};
        el[0][0] = 32'h3F800000; el[0][1] = 32'h40400000; el[0][2] = 32'h40000000;
        run_table("basic", 1, lens, el, want, wa, wb);
    endtask

    task automatic test_negative;
        int lens[4] = '{2, 2, 0, 0};
        logic [31:0] el[4][8] = '{default: '{default: 32'h0}};
        logic [31:0] want[4] = '{32'hBF800000, 32'h00000000, 0, 0};
        int wa[4] = '{2, 2, 0, 0};
        int wb[4] = '{2, 2, 0, 0};
        el[0][0] = 32'hC0000000; el[0][1] = 32'hBF800000;
        el[1][0] = 32'h80000000; el[1][1] = 32'h00000000;
        run_table("negative", 2, lens, el, want, wa, wb);
    endtask

    task automatic test_saturation;
        int lens[4] = '{5, 0, 0, 0};
        logic [31:0] el[4][8] = '{default: '{default: 32'h0}};
        logic [31:0] want[4] = '{32'h42C80000, 0, 0, 0};
        int wa[4] = '{5, 0, 0, 0};
        int wb[4] = '{3, 0, 0, 0};
        el[0][0] = 32'h3F800000; el[0][1] = 32'h40000000; el[0][2] = 32'hC0000000;
        el[0][3] = 32'h40400000; el[0][4] = 32'h42C80000;
        run_table("saturate", 1, lens, el, want, wa, wb);
    endtask

    task automatic test_nan;
        int lens[4] = '{2, 2, 0, 0};
        logic [31:0] el[4][8] = '{default: '{default: 32'h0}};
`ifdef FMAX_NAN_EN
        logic [31:0] want[4] = '{32'h3F800000, 32'h7FC00000, 0, 0};
`else
        logic [31:0] want[4] = '{32'h7FC00000, 32'h7FC00001, 0, 0};
`endif
        int wa[4] = '{2, 2, 0, 0};
        int wb[4] = '{2, 2, 0, 0};
        el[0][0] = 32'h7FC00000; el[0][1] = 32'h3F800000;
        el[1][0] = 32'h7FC00001; el[1][1] = 32'hFFC00000;
        run_table("nan", 2, lens, el, want, wa, wb);
    endtask

    task automatic test_back_to_back;
        bit ok, lat, rok;
        logic [31:0] da, db;
        int ca, cb;
        exp_t e;
        set_ready(1'b0);
        pkt[0] = 32'h41200000;
        sb.push_back('{32'h41200000, 1, 1});
        send(1, ok, lat);
        checks++;
        if (!ok || !lat) begin
            errors++; $display("FAIL b2b_latency got accept %b valid %b want 1 1", ok, lat);
        end
        // Second packet presented during the stall; it must not be taken.
        drive(1'b1, 32'hFF800000, 1'b1);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (ifa.in_ready !== 1'b0 || ifa.out_valid !== 1'b1 || ifa.out_data !== 32'h41200000
                || ifb.out_data !== 32'h41200000) begin
                errors++; $display("FAIL b2b_stall cyc %0d got rdy %b vld %b data %h want 0 1 41200000",
                                   c, ifa.in_ready, ifa.out_valid, ifa.out_data);
            end
            @(posedge clk); #1;
        end
        sb.push_back('{32'hFF800000, 1, 1});
        recv(rok, da, ca, db, cb);
        e = sb.pop_front();
        checks++;
        if (!rok || da !== e.d || db !== e.d || ca !== e.ca || cb !== e.cb) begin
            errors++; $display("FAIL b2b_first got ok %b data %h/%h count %0d/%0d want %h %0d", rok, da, db, ca, cb, e.d, e.ca);
        end
        checks++;
        if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifb.out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_bubble got vld %b rdy %b want 0 1", ifa.out_valid, ifa.in_ready);
        end
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0);
        checks++;
        if (ifa.out_valid !== 1'b1 || ifb.out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_second_latency got vld %b/%b want 1", ifa.out_valid, ifb.out_valid);
        end
        recv(rok, da, ca, db, cb);
        e = sb.pop_front();
        checks++;
        if (!rok || da !== e.d || db !== e.d || ca !== e.ca || cb !== e.cb) begin
            errors++; $display("FAIL b2b_second got ok %b data %h/%h count %0d/%0d want %h %0d", rok, da, db, ca, cb, e.d, e.ca);
        end
    endtask

    task automatic test_reset_mid;
        bit ok, lat, rok, leaked;
        logic [31:0] da, db;
        int ca, cb;
        exp_t e;
        set_ready(1'b1);
        drive(1'b1, 32'h3F800000, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 32'h40000000, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifa.out_count !== 16'd0 || ifb.out_count !== 2'd0) begin
            errors++; $display("FAIL midrst_state got vld %b rdy %b count %0d want 0 1 0", ifa.out_valid, ifa.in_ready, ifa.out_count);
        end
        leaked = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (ifa.out_valid || ifb.out_valid) leaked = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (leaked !== 1'b0) begin
            errors++; $display("FAIL midrst_leak got out_valid after reset want none");
        end
        pkt[0] = 32'h3F000000;
        sb.push_back('{32'h3F000000, 1, 1});
        send(1, ok, lat);
        recv(rok, da, ca, db, cb);
        e = sb.pop_front();
        checks++;
        if (!ok || !lat || !rok || da !== e.d || db !== e.d || ca !== e.ca || cb !== e.cb) begin
            errors++; $display("FAIL midrst_fresh got ok %b%b%b data %h/%h count %0d/%0d want %h %0d",
                               ok, lat, rok, da, db, ca, cb, e.d, e.ca);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        set_ready(1'b1);
        test_reset;
        test_basic;
        test_negative;
        test_back_to_back;
        test_reset_mid;
        test_saturation;
        test_nan;
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fmax_reduce.md
Name: fmax_reduce

Overview:
- Streaming IEEE-754 single-precision maximum-reduction unit, the max-direction companion of the FPU's combinational min/select logic.
- Accepts a packet of 32-bit floats over a valid/ready stream terminated by a last flag.
- Emits one result beat per packet carrying the packet maximum and the element count.
- Sits behind the FPU operand path for vector reduction (max-pool, range finding).

Parameters:
- CNT_W, 16, width of the element counter and of out_count; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit can accept an input beat.
- in_data  input  32  IEEE-754 single operand.
- in_last  input  1  marks the final element of the packet.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  packet maximum, bit-exact copy of one input element.
- out_count  output  CNT_W  number of elements accepted in the packet, saturating.

Behaviour:
- Reset, with rst high at a clock edge:
  - state=EMPTY, acc=0x00000000, cnt=0.
  - out_valid=0, out_data=0x00000000, out_count=0, in_ready=1.
  - Reset mid-packet or mid-DONE discards all partial and pending results; nothing is emitted afterwards.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer when out_valid && out_ready.
- States:
  - EMPTY: in_ready=1, out_valid=0. On an input transfer: acc=in_data, cnt=1. Go to DONE if in_last, else ACCUM.
  - ACCUM: in_ready=1, out_valid=0. On an input transfer: acc=gt(in_data,acc) ? in_data : acc; cnt=sat(cnt+1). Go to DONE if in_last.
  - DONE: in_ready=0, out_valid=1, out_data=acc, out_count=cnt. On an output transfer: EMPTY, cnt=0; acc holds its value.
- Timing:
  - out_valid rises the cycle after the in_last beat is accepted (latency 1).
  - Throughput is one element per cycle within a packet.
  - One bubble cycle between packets (DONE blocks input). No input is accepted in the cycle of the output handshake.
- Ordering, gt(a,b), with magnitude = {exp,mantissa} as an unsigned 31-bit value:
  - Signs differ: the positive operand is greater, so +0 (0x00000000) beats -0 (0x80000000).
  - Both positive: the larger magnitude is greater.
  - Both negative: the smaller magnitude is greater.
  - Equal bit patterns: gt=0, so the earlier element is retained.
  - Infinities follow naturally: +inf beats everything non-NaN.
  - Denormals are compared by raw bits; no flushing.
- Counter: cnt is CNT_W bits; once at all-ones it stays there, while the reduction continues normally.
- Single-element packet (in_last on the first beat) outputs that element unchanged with count 1.
- out_data/out_count are stable while out_valid && !out_ready.
- Inputs are ignored while in DONE; upstream must hold in_valid/data per handshake rules.

Optional Feature:
- Macro: FMAX_NAN_EN.
- Defined (IEEE maxNum NaN handling):
  - A NaN input (exp=0xFF, mantissa!=0) is never selected over a non-NaN accumulator.
  - A non-NaN input always replaces a NaN accumulator.
  - A first-element NaN is loaded provisionally.
  - If every element of the packet is NaN, out_data=0x7FC00000 (canonical qNaN).
  - out_count still counts NaN elements.
- Undefined: NaNs receive no special treatment; they are ordered by raw bits per gt(). Example: 0x7FC00000 beats 0x7F800000 (+inf).

Test Plan:
- Reset then packet {0x3F800000, 0x40400000, 0x40000000(last)} -> out_data=0x40400000, out_count=3, out_valid one cycle after the last beat.
- Negative packet {0xC0000000, 0xBF800000(last)} -> out_data=0xBF800000 (-1.0); packet {0x80000000, 0x00000000(last)} -> 0x00000000.
- Back-to-back single-element packets 0x41200000(last) then 0xFF800000(last), with out_ready held low 3 cycles on the first:
  - in_ready=0 and out_data stable during the stall.
  - Results are 0x41200000 then 0xFF800000.
  - One bubble between packets.
- rst asserted after 2 of 4 beats: next cycle out_valid=0, in_ready=1, out_count=0. A fresh packet {0x3F000000(last)} -> 0x3F000000, count 1.
- CNT_W=2, 5-element packet with max 0x42C80000 at position 5 -> out_count=3 (saturated), out_data=0x42C80000.
- FMAX_NAN_EN:
  - {0x7FC00000, 0x3F800000(last)} -> 0x3F800000.
  - {0x7FC00001, 0xFFC00000(last)} -> 0x7FC00000.
  - Without the macro, the first packet -> 0x7FC00000.
